// File: rtl/drum_prod_accum.sv
// Frame accumulator for unsigned DRUM products: saturating sum and beat count per frame,
// with the result held for a valid/ready handshake before the next frame starts.
module drum_prod_accum #(
    parameter int unsigned ACC_W = 40,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_sat
);

    localparam logic ST_ACC = 1'b0;
    localparam logic ST_OUT = 1'b1;

    logic             r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic [ACC_W-1:0] r_out_sum;
    logic [CNT_W-1:0] r_out_cnt;
    logic             r_out_sat;

    logic [ACC_W:0]   w_sum_wide;
    logic             w_ovf;
    logic [ACC_W-1:0] w_acc_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_sat_next;
    logic             w_close;
    logic             w_accept;
    logic             w_xfer;

    assign in_ready  = (r_state == ST_ACC);
    assign out_valid = (r_state == ST_OUT);
    assign out_sum   = r_out_sum;
    assign out_cnt   = r_out_cnt;
    assign out_sat   = r_out_sat;

    assign w_accept = in_valid && in_ready;
    assign w_xfer   = out_valid && out_ready;

    // One extra bit catches the carry out of the accumulator; that carry is the saturation condition.
    assign w_sum_wide = {1'b0, r_acc} + {{(ACC_W + 1 - 32){1'b0}}, in_prod};
    assign w_ovf      = w_sum_wide[ACC_W];
    assign w_acc_next = w_ovf ? '1 : w_sum_wide[ACC_W-1:0];
    assign w_sat_next = r_sat | w_ovf;
    assign w_cnt_next = r_cnt + 1'b1;
    assign w_close    = in_last || (w_cnt_next == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_ACC;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sat     <= 1'b0;
            r_out_sum <= '0;
            r_out_cnt <= '0;
            r_out_sat <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
            r_sat <= w_sat_next;
            if (w_close) begin
                r_state   <= ST_OUT;
                r_out_sum <= w_acc_next;
                r_out_cnt <= w_cnt_next;
                r_out_sat <= w_sat_next;
            end
        end else if (w_xfer) begin
            r_state <= ST_ACC;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end
    end

endmodule
